// File: rtl/rv_pkg.sv
// Shared RV32 constants, fetch FSM encoding and the fetch FIFO entry layout.
package rv_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head view and a flush input.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push, do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign count = count_reg;
  assign rdata = mem[rd_ptr_reg];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues req/gnt/rvalid word reads, buffers
// returned words with their PC and hands them to decode; redirects flush stale work.
module instr_fetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [0:0]      state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            req_reg, req_next;
  logic [CW-1:0]   live_reg, live_next;
  logic [CW-1:0]   stale_reg, stale_next;
  logic [CW-1:0]   data_count, data_count_next;
  logic [SW-1:0]   pending_next;
  logic            grant, rsp_ok, rsp_stale, push, pop;
  logic            data_empty, data_full;
  logic            shadow_empty, shadow_full;
  logic [CW-1:0]   shadow_count;
  logic [XLEN-1:0] req_pc_head;
  fetch_entry_t    push_entry, head_entry;
  logic            unused_sigs;

  assign grant     = req_reg && imem_gnt && (state_reg == ST_RUN);
  // Responses with nothing outstanding are ignored entirely.
  assign rsp_ok    = imem_rvalid && ((live_reg != '0) || (stale_reg != '0));
  assign rsp_stale = (stale_reg != '0);
  assign push      = rsp_ok && !rsp_stale && !redirect;

  assign instr_valid = !data_empty && !redirect;
  assign pop         = instr_valid && instr_ready;
  assign instr       = data_empty ? '0 : head_entry.instr;
  assign instr_pc    = data_empty ? '0 : head_entry.pc;

  assign imem_req  = req_reg;
  assign imem_addr = pc_reg;

  assign push_entry  = '{pc: req_pc_head, instr: imem_rdata};
  assign unused_sigs = ^{data_full, shadow_empty, shadow_full, shadow_count, redirect_pc[1:0]};

  always_comb begin
    state_next      = ST_RUN;
    pc_next         = pc_reg;
    live_next       = live_reg;
    stale_next      = stale_reg;
    data_count_next = data_count;
    if (redirect) begin
      // Everything still in flight, including a grant this cycle, becomes stale.
      state_next      = ST_FLUSH;
      pc_next         = {redirect_pc[XLEN-1:2], 2'b00};
      live_next       = '0;
      stale_next      = stale_reg + live_reg + CW'(grant) - CW'(rsp_ok);
      data_count_next = '0;
    end else begin
      if (grant) pc_next = pc_reg + XLEN'(INSTR_BYTES);
      live_next       = live_reg + CW'(grant) - CW'(rsp_ok && !rsp_stale);
      stale_next      = stale_reg - CW'(rsp_ok && rsp_stale);
      data_count_next = data_count + CW'(push) - CW'(pop);
    end
    // Every request reserves a FIFO slot, so buffered + in-flight never exceeds DEPTH.
    pending_next = SW'(data_count_next) + SW'(live_next) + SW'(stale_next);
    req_next     = (state_next == ST_RUN) && (pending_next < SW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_RUN;
      pc_reg    <= RESET_PC;
      req_reg   <= 1'b0;
      live_reg  <= '0;
      stale_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      req_reg   <= req_next;
      live_reg  <= live_next;
      stale_reg <= stale_next;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN)) u_data_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .flush (redirect),
    .rdata (head_entry),
    .full  (data_full),
    .empty (data_empty),
    .count (data_count)
  );

  // Addresses of every granted request, stale or not, in response order.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_req_pc_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (grant),
    .wdata (pc_reg),
    .pop   (rsp_ok),
    .flush (1'b0),
    .rdata (req_pc_head),
    .full  (shadow_full),
    .empty (shadow_empty),
    .count (shadow_count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a tagged memory model and an expected-delivery queue.
module tb_instr_fetch #(parameter logic [31:0] RESET_PC_TB = 32'h0000_0000);
  localparam int DEPTH_TB = 2;

  logic        clk = 1'b0, reset = 1'b1;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        redirect = 1'b0, instr_valid, instr_ready = 1'b0;
  logic [31:0] redirect_pc = '0, instr, instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC_TB), .DEPTH(DEPTH_TB)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  int n_cmp = 0, n_err = 0;

  // Memory model: outstanding reads tagged with the redirect epoch they were issued in.
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          mq_ep[$];
  // Expected decode-side queue and logs of what the DUT actually did.
  logic [31:0] exp_q[$];
  logic [31:0] grant_log[$];
  int          grant_cyc[$];
  logic [31:0] deliv_pc[$];
  logic [31:0] deliv_instr[$];

  int          cyc = 0, epoch = 0, lat = 1, hold_left = 0, busy_hit = 0;
  int          first_valid_cyc = -1;
  logic [31:0] issue_pc = RESET_PC_TB, redir_tgt = '0, hold_addr = '0;
  logic        gnt_en = 1'b0, ready_ctl = 1'b0, redir_req = 1'b0, redir_on_busy = 1'b0;
  logic        prev_wait = 1'b0, prev_redir = 1'b0, prev_stall = 1'b0;
  logic [31:0] prev_addr = '0, prev_instr = '0, prev_ipc = '0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h7A08_01EF ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq_addr.delete(); mq_due.delete(); mq_ep.delete(); exp_q.delete();
    grant_log.delete(); grant_cyc.delete(); deliv_pc.delete(); deliv_instr.delete();
    issue_pc = RESET_PC_TB; first_valid_cyc = -1;
    prev_wait = 1'b0; prev_redir = 1'b0; prev_stall = 1'b0;
  endtask

  // One bus cycle: drive at negedge, check #1 later, then account for the coming edge.
  task automatic step();
    logic do_rv, do_gnt, do_redir, grant, pop_exp;
    int   outst;
    logic [31:0] a;
    int   ep;
    @(negedge clk);
    cyc++;
    do_rv  = (mq_addr.size() != 0) && (mq_due[0] <= cyc);
    do_gnt = gnt_en;
    if (hold_left > 0 && imem_req && imem_addr == hold_addr) begin
      do_gnt = 1'b0;
      hold_left--;
    end
    do_redir = redir_req || (redir_on_busy && imem_req && do_gnt && do_rv);
    if (redir_on_busy && do_redir) begin
      busy_hit++;
      redir_on_busy = 1'b0;
    end
    redir_req   = 1'b0;
    imem_gnt    = do_gnt;
    imem_rvalid = do_rv;
    imem_rdata  = do_rv ? word_at(mq_addr[0]) : 32'hDEAD_BEEF;
    redirect    = do_redir;
    redirect_pc = redir_tgt;
    instr_ready = ready_ctl;
    #1;
    outst = mq_addr.size();
    chk("issue_rule", 32'(imem_req), 32'(!prev_redir && (exp_q.size() + outst < DEPTH_TB)));
    chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
    chk("pending_cap", 32'(outst + exp_q.size() <= DEPTH_TB), 32'd1);
    if (prev_wait) begin
      chk("req_hold", 32'(imem_req), 32'd1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0 && !do_redir));
    if (exp_q.size() != 0) begin
      chk("instr_pc", instr_pc, exp_q[0]);
      chk("instr", instr, word_at(exp_q[0]));
    end
    if (prev_stall && !do_redir) begin
      chk("stall_instr", instr, prev_instr);
      chk("stall_pc", instr_pc, prev_ipc);
    end
    if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;

    grant   = imem_req && do_gnt;
    pop_exp = (exp_q.size() != 0) && !do_redir && ready_ctl;
    if (grant) begin
      chk("grant_addr", imem_addr, issue_pc);
      grant_log.push_back(imem_addr);
      grant_cyc.push_back(cyc);
      mq_addr.push_back(issue_pc); mq_due.push_back(cyc + lat); mq_ep.push_back(epoch);
      issue_pc = issue_pc + 32'd4;
    end
    if (pop_exp) begin
      deliv_pc.push_back(instr_pc);
      deliv_instr.push_back(instr);
      void'(exp_q.pop_front());
    end
    if (do_rv) begin
      a = mq_addr.pop_front(); void'(mq_due.pop_front()); ep = mq_ep.pop_front();
      if (ep == epoch && !do_redir) exp_q.push_back(a);
    end
    if (do_redir) begin
      exp_q.delete();
      issue_pc = {redir_tgt[31:2], 2'b00};
      epoch++;
    end
    prev_wait  = imem_req && !do_gnt && !do_redir;
    prev_redir = do_redir;
    prev_stall = instr_valid && !ready_ctl && !do_redir;
    prev_addr  = imem_addr;
    prev_instr = instr;
    prev_ipc   = instr_pc;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, RESET_PC_TB);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_ipc"}, instr_pc, 32'd0);
  endtask

  // Asserts reset between edges, checks it acted immediately, releases at a negedge.
  task automatic async_reset(input string tag);
    reset = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
    #1;
    check_reset_vals(tag);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Power-on reset.
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("por");
    model_clear();
    @(negedge clk);
    reset = 1'b1;

    // Streaming fetch with single-cycle memory.
    gnt_en = 1'b1; lat = 1; ready_ctl = 1'b1;
    repeat (12) step();
    chk("first_grant_addr", grant_log.size() > 0 ? grant_log[0] : 32'hFFFF_FFFF, RESET_PC_TB);
    chk("grant_addr_2", grant_log.size() > 2 ? grant_log[2] : 32'hFFFF_FFFF, RESET_PC_TB + 32'd8);
    chk("first_valid_latency", 32'(first_valid_cyc - (grant_cyc.size() > 0 ? grant_cyc[0] : 0)), 32'd2);
    chk("first_instr", deliv_instr.size() > 0 ? deliv_instr[0] : 32'h0, 32'h7A08_01EF ^ RESET_PC_TB);
    chk("first_ipc", deliv_pc.size() > 0 ? deliv_pc[0] : 32'hFFFF_FFFF, RESET_PC_TB);
    chk("stream_progress", 32'(deliv_pc.size() >= 4), 32'd1);

    // Fill the FIFO, then reset asynchronously mid-cycle.
    ready_ctl = 1'b0;
    repeat (4) step();
    #2;
    chk("pre_reset_valid", 32'(instr_valid), 32'd1);
    async_reset("midrst");

    // Backpressure from a fresh start.
    repeat (6) step();
    chk("bp_grants", 32'(grant_log.size()), 32'd2);
    chk("bp_req_low", 32'(imem_req), 32'd0);
    ready_ctl = 1'b1;
    repeat (4) step();
    chk("bp_deliv0", deliv_pc.size() > 0 ? deliv_pc[0] : 32'hFFFF_FFFF, RESET_PC_TB);
    chk("bp_deliv1", deliv_pc.size() > 1 ? deliv_pc[1] : 32'hFFFF_FFFF, RESET_PC_TB + 32'd4);

    // Redirect with two reads outstanding.
    @(negedge clk); #3;
    async_reset("rst3");
    lat = 3; ready_ctl = 1'b1; gnt_en = 1'b1;
    for (int i = 0; i < 10 && mq_addr.size() < 2; i++) step();
    chk("two_outstanding", 32'(mq_addr.size()), 32'd2);
    redir_tgt = 32'h0000_07D3; redir_req = 1'b1;
    step();
    grant_log.delete(); deliv_pc.delete(); deliv_instr.delete();
    repeat (14) step();
    chk("redir_first_grant", grant_log.size() > 0 ? grant_log[0] : 32'hFFFF_FFFF, 32'h0000_07D0);
    chk("redir_first_ipc", deliv_pc.size() > 0 ? deliv_pc[0] : 32'hFFFF_FFFF, 32'h0000_07D0);
    chk("redir_first_instr", deliv_instr.size() > 0 ? deliv_instr[0] : 32'h0, 32'h7A08_063F);

    // Redirect in the same cycle as a grant and a response.
    @(negedge clk); #3;
    async_reset("rst4");
    lat = 1; redir_tgt = 32'h0000_1002; redir_on_busy = 1'b1;
    for (int i = 0; i < 10 && busy_hit == 0; i++) step();
    chk("busy_redirect_hit", 32'(busy_hit), 32'd1);
    redir_on_busy = 1'b0;
    grant_log.delete(); deliv_pc.delete(); deliv_instr.delete();
    repeat (12) step();
    chk("busy_first_grant", grant_log.size() > 0 ? grant_log[0] : 32'hFFFF_FFFF, 32'h0000_1000);
    chk("busy_first_ipc", deliv_pc.size() > 0 ? deliv_pc[0] : 32'hFFFF_FFFF, 32'h0000_1000);
    chk("busy_progress", 32'(deliv_pc.size() >= 4), 32'd1);

    // Slow grant at the third address.
    @(negedge clk); #3;
    async_reset("rst5");
    lat = 1; hold_addr = RESET_PC_TB + 32'd8; hold_left = 5;
    repeat (14) step();
    chk("hold_consumed", 32'(hold_left), 32'd0);
    chk("hold_grant_gap", grant_cyc.size() > 2 ? 32'(grant_cyc[2] - grant_cyc[1]) : 32'd0, 32'd7);
    chk("hold_next_addr", grant_log.size() > 3 ? grant_log[3] : 32'hFFFF_FFFF, RESET_PC_TB + 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
